// File: rtl/operand_loader_pkg.sv
// Shared definitions for the operand loader: state encoding, FIFO sizing and length clamp.
package operand_loader_pkg;

    localparam int DATA_W         = 32;
    localparam int FIFO_DEPTH_DEF = 8;
    localparam int MAX_LEN        = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        PAD  = 2'b10,
        DONE = 2'b11
    } state_t;

    function automatic logic [3:0] clamp_len(input logic [3:0] len);
        return (len > 4'(MAX_LEN)) ? 4'(MAX_LEN) : len;
    endfunction

endpackage

// File: rtl/operand_loader_ns.sv
// Next-state logic for the operand loader: state, length latch, write count and host ready.
module operand_loader_ns
    import operand_loader_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic [1:0] i_state,
    input  logic [3:0] i_len,
    input  logic [3:0] i_cnt,
    input  logic [3:0] i_load_len,
    input  logic       i_start,
    input  logic       i_clear,
    input  logic       i_din_valid,
    input  logic [3:0] i_fifo_count,
    input  logic       i_fifo_we,
    output logic [1:0] o_state_nxt,
    output logic [3:0] o_len_nxt,
    output logic [3:0] o_cnt_nxt,
    output logic       o_din_ready,
    output logic       o_wr,
    output logic       o_wr_pad,
    output logic       o_load_start
);

    localparam logic [4:0] DEPTH5 = 5'(FIFO_DEPTH);

    state_t     w_state;
    state_t     w_nxt;
    logic [4:0] w_occ;
    logic       w_space;
    logic [3:0] w_remaining;
    logic [3:0] w_len_new;
    logic       w_ready;

    assign w_state     = state_t'(i_state);
    // The write already registered this cycle lands next edge, so it counts as occupied.
    assign w_occ       = {1'b0, i_fifo_count} + {4'b0, i_fifo_we};
    assign w_space     = (w_occ < DEPTH5);
    assign w_remaining = i_len - i_cnt;
    assign w_len_new   = clamp_len(i_load_len);
    assign w_ready     = (w_state == LOAD) && (w_remaining != 4'd0) && w_space;

    always_comb begin
        w_nxt        = w_state;
        o_len_nxt    = i_len;
        o_cnt_nxt    = i_cnt;
        o_wr         = 1'b0;
        o_wr_pad     = 1'b0;
        o_load_start = 1'b0;
        case (w_state)
            IDLE: begin
                if (i_start) begin
                    o_len_nxt = w_len_new;
                    o_cnt_nxt = 4'd0;
                    if (w_len_new == 4'd0) begin
                        w_nxt = DONE;
                    end else begin
                        w_nxt        = LOAD;
                        o_load_start = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (i_din_valid && w_ready) begin
                    o_wr      = 1'b1;
                    o_cnt_nxt = i_cnt + 4'd1;
                    if (w_remaining == 4'd1) begin
                        w_nxt = i_len[0] ? PAD : DONE;
                    end
                end
            end
            PAD: begin
                if (w_space) begin
                    o_wr      = 1'b1;
                    o_wr_pad  = 1'b1;
                    o_cnt_nxt = i_cnt + 4'd1;
                    w_nxt     = DONE;
                end
            end
            DONE: begin
                if (!i_start) begin
                    w_nxt = IDLE;
                end
            end
            default: w_nxt = IDLE;
        endcase
        if (i_clear) begin
            w_nxt        = IDLE;
            o_len_nxt    = i_len;
            o_cnt_nxt    = 4'd0;
            o_wr         = 1'b0;
            o_wr_pad     = 1'b0;
            o_load_start = 1'b0;
        end
    end

    assign o_state_nxt = w_nxt;
    assign o_din_ready = w_ready;

endmodule

// File: rtl/operand_loader.sv
// Operand FIFO producer: loads a programmed word count from the host, zero-pads odd counts.
// Optional running sum output enabled by defining OPERAND_LOADER_SUM_EN.
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_start,
    input  logic              op_clear,
    input  logic [3:0]        load_len,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic [3:0]        fifo_data_count,
    output logic              fifo_we,
    output logic [DATA_W-1:0] fifo_dout,
    output logic [3:0]        loaded_count,
    output logic              op_done
`ifdef OPERAND_LOADER_SUM_EN
    ,
    output logic [DATA_W-1:0] sum_out
`endif
);

    state_t            r_state;
    logic [3:0]        r_len;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [DATA_W-1:0] r_dout;

    logic [1:0]        w_state_nxt;
    logic [3:0]        w_len_nxt;
    logic [3:0]        w_cnt_nxt;
    logic              w_din_ready;
    logic              w_wr;
    logic              w_wr_pad;
    logic              w_load_start;

    operand_loader_ns #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_ns (
        .i_state     (r_state),
        .i_len       (r_len),
        .i_cnt       (r_cnt),
        .i_load_len  (load_len),
        .i_start     (op_start),
        .i_clear     (op_clear),
        .i_din_valid (din_valid),
        .i_fifo_count(fifo_data_count),
        .i_fifo_we   (r_we),
        .o_state_nxt (w_state_nxt),
        .o_len_nxt   (w_len_nxt),
        .o_cnt_nxt   (w_cnt_nxt),
        .o_din_ready (w_din_ready),
        .o_wr        (w_wr),
        .o_wr_pad    (w_wr_pad),
        .o_load_start(w_load_start)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_len   <= 4'd0;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_state <= state_t'(w_state_nxt);
            r_len   <= w_len_nxt;
            r_cnt   <= w_cnt_nxt;
            r_we    <= w_wr;
            if (w_wr) begin
                r_dout <= w_wr_pad ? '0 : din;
            end
        end
    end

`ifdef OPERAND_LOADER_SUM_EN
    logic [DATA_W-1:0] r_sum;

    // Pad writes add nothing, so only real host beats accumulate.
    always_ff @(posedge clk) begin
        if (reset || op_clear || w_load_start) begin
            r_sum <= '0;
        end else if (w_wr && !w_wr_pad) begin
            r_sum <= r_sum + din;
        end
    end

    assign sum_out = r_sum;
`endif

    assign din_ready    = w_din_ready;
    assign fifo_we      = r_we;
    assign fifo_dout    = r_dout;
    assign loaded_count = r_cnt;
    assign op_done      = (r_state == DONE);

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader: vector table, corner sequences, random loads vs. a queue model.
module tb_operand_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_start;
    logic        op_clear;
    logic [3:0]  load_len;
    logic [31:0] din;
    logic        din_valid;
    logic        din_ready;
    logic [3:0]  fifo_data_count;
    logic        fifo_we;
    logic [31:0] fifo_dout;
    logic [3:0]  loaded_count;
    logic        op_done;
`ifdef OPERAND_LOADER_SUM_EN
    logic [31:0] sum_out;
`endif

    int          n_checks = 0;
    int          n_err    = 0;
    int          occ      = 0;
    int          drain_pct = 100;
    bit          ovr_en   = 1'b0;
    logic [3:0]  ovr_cnt  = 4'd0;
    logic [31:0] exp_q[$];
    logic [31:0] sum_model = 32'd0;

    typedef struct {
        logic [3:0]  len;
        logic [31:0] base;
        int          vpct;
        int          dpct;
        int          exp_cnt;
        bit          chk_span;
    } vec_t;
    vec_t vt[8];

    operand_loader dut (
        .clk            (clk),
        .reset          (reset),
        .op_start       (op_start),
        .op_clear       (op_clear),
        .load_len       (load_len),
        .din            (din),
        .din_valid      (din_valid),
        .din_ready      (din_ready),
        .fifo_data_count(fifo_data_count),
        .fifo_we        (fifo_we),
        .fifo_dout      (fifo_dout),
        .loaded_count   (loaded_count),
        .op_done        (op_done)
`ifdef OPERAND_LOADER_SUM_EN
        ,
        .sum_out        (sum_out)
`endif
    );

    always #5 clk = ~clk;

    assign fifo_data_count = ovr_en ? ovr_cnt : 4'(occ);

    // Downstream FIFO model: a write lands on the edge, the adder drains at a random rate.
    always @(posedge clk) begin
        if (reset) begin
            occ <= 0;
        end else if (occ > 0 && $urandom_range(99) < drain_pct) begin
            occ <= occ + int'(fifo_we) - 1;
        end else begin
            occ <= occ + int'(fifo_we);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (fifo_we === 1'b1) begin
            if (exp_q.size() == 0) check("unexpected_write", 32'(fifo_we), 32'd0);
            else                   check("write_data", fifo_dout, exp_q.pop_front());
        end
        if (!ovr_en) check("fifo_no_overflow", 32'(occ <= 8), 32'd1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_load(input logic [3:0] len, input logic [31:0] base, input bit rnd,
                            input int vpct, input int dpct, input int exp_cnt, input bit chk_span);
        int          L;
        int          idx;
        int          first_we;
        bit          done;
        logic [31:0] words[8];
        logic [31:0] esum;
        L    = (len > 4'd8) ? 8 : int'(len);
        esum = 32'd0;
        for (int i = 0; i < L; i++) begin
            words[i] = rnd ? 32'($urandom) : base + 32'(i);
            exp_q.push_back(words[i]);
            esum += words[i];
        end
        if (L % 2 == 1) exp_q.push_back(32'd0);
        if (L > 0) sum_model = esum;
        drain_pct = dpct;
        tick();
        op_start  = 1'b1;
        load_len  = len;
        idx       = 0;
        din_valid = (L > 0);
        din       = (L > 0) ? words[0] : 32'd0;
        done      = 1'b0;
        first_we  = -1;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge clk);
            if (fifo_we && first_we < 0) first_we = cyc;
            if (op_done) begin
                done = 1'b1;
                check("done_with_last_write", 32'(fifo_we), 32'(L > 0));
                check("done_loaded_count", 32'(loaded_count), 32'(exp_cnt));
                if (chk_span && L > 0) check("back_to_back_span", 32'(cyc - first_we), 32'(exp_cnt - 1));
            end else begin
                if (din_valid && din_ready) idx++;
                @(posedge clk);
                #1;
                din_valid = (idx < L) && ($urandom_range(99) < vpct);
                din       = (idx < L) ? words[idx] : 32'($urandom);
            end
        end
        if (!done) check("done_timeout", 32'(op_done), 32'd1);
        din_valid = 1'b0;
        tick();
        check("done_hold", 32'(op_done), 32'd1);
        check("writes_outstanding", 32'(exp_q.size()), 32'd0);
`ifdef OPERAND_LOADER_SUM_EN
        check("sum_out", sum_out, sum_model);
`endif
        op_start = 1'b0;
        tick();
        check("idle_after_drop", 32'(op_done), 32'd0);
        check("count_holds", 32'(loaded_count), 32'(exp_cnt));
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b1; op_start = 1'b0; op_clear = 1'b0; load_len = 4'd0;
        din = 32'd0; din_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_fifo_we", 32'(fifo_we), 32'd0);
        check("rst_fifo_dout", fifo_dout, 32'd0);
        check("rst_loaded_count", 32'(loaded_count), 32'd0);
        check("rst_op_done", 32'(op_done), 32'd0);
        check("rst_din_ready", 32'(din_ready), 32'd0);

        vt[0] = '{4'd4,  32'd1,          100, 100, 4, 1'b1};
        vt[1] = '{4'd3,  32'd5,          100, 100, 4, 1'b1};
        vt[2] = '{4'd0,  32'd0,          100, 100, 0, 1'b0};
        vt[3] = '{4'd12, 32'h100,        100, 100, 8, 1'b1};
        vt[4] = '{4'd1,  32'hFFFF_FFF0,  100, 100, 2, 1'b1};
        vt[5] = '{4'd7,  32'h70,          60, 100, 8, 1'b0};
        vt[6] = '{4'd8,  32'hFFFF_FFFC,  100,  50, 8, 1'b0};
        vt[7] = '{4'd15, 32'h1000,        70,  40, 8, 1'b0};
        for (int v = 0; v < 8; v++) begin
            run_load(vt[v].len, vt[v].base, 1'b0, vt[v].vpct, vt[v].dpct, vt[v].exp_cnt, vt[v].chk_span);
        end
        drain_pct = 100;
        repeat (4) tick();

        // Backpressure: count 7 plus one pending write blocks the host.
        exp_q.push_back(32'hA0); exp_q.push_back(32'hA1);
        ovr_en = 1'b1; ovr_cnt = 4'd6;
        op_start = 1'b1; load_len = 4'd2; din_valid = 1'b1; din = 32'hA0;
        tick(); #1;
        check("bp_ready_at6", 32'(din_ready), 32'd1);
        tick();
        ovr_cnt = 4'd7; din = 32'hA1; #1;
        check("bp_first_write", 32'(fifo_we), 32'd1);
        check("bp_ready_7_pending", 32'(din_ready), 32'd0);
        tick();
        check("bp_no_write_at_full", 32'(fifo_we), 32'd0);
        ovr_cnt = 4'd6; #1;
        check("bp_ready_after_drop", 32'(din_ready), 32'd1);
        tick();
        check("bp_second_write", 32'(fifo_we), 32'd1);
        check("bp_done", 32'(op_done), 32'd1);
        check("bp_count", 32'(loaded_count), 32'd2);
        sum_model = 32'h141;
        ovr_en = 1'b0; din_valid = 1'b0; op_start = 1'b0;
        tick();
        check("bp_idle", 32'(op_done), 32'd0);
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        // Clear after two accepted words of six.
        exp_q.push_back(32'hC0); exp_q.push_back(32'hC1);
        op_start = 1'b1; load_len = 4'd6; din_valid = 1'b1; din = 32'hC0;
        tick(); #1;
        check("clr_ready", 32'(din_ready), 32'd1);
        tick();
        din = 32'hC1; #1;
        check("clr_write0", 32'(fifo_we), 32'd1);
        tick();
        din_valid = 1'b0; op_clear = 1'b1; #1;
        check("clr_inflight_write", 32'(fifo_we), 32'd1);
        check("clr_count_before", 32'(loaded_count), 32'd2);
        tick();
        op_clear = 1'b0; op_start = 1'b0; #1;
        check("clr_we_dropped", 32'(fifo_we), 32'd0);
        check("clr_count_zero", 32'(loaded_count), 32'd0);
        check("clr_no_done", 32'(op_done), 32'd0);
        check("clr_idle_ready", 32'(din_ready), 32'd0);
        sum_model = 32'd0;
        tick();
        check("clr_still_idle", 32'(op_done), 32'd0);
        check("clr_queue_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        // Clear beats start in IDLE.
        op_start = 1'b1; op_clear = 1'b1; load_len = 4'd4;
        tick(); #1;
        check("clear_over_start_ready", 32'(din_ready), 32'd0);
        check("clear_over_start_done", 32'(op_done), 32'd0);
        op_start = 1'b0; op_clear = 1'b0;
        tick();

        // Reset while stalled in PAD: no pad write may follow.
        exp_q.push_back(32'hD1);
        ovr_en = 1'b1; ovr_cnt = 4'd6;
        op_start = 1'b1; load_len = 4'd1; din_valid = 1'b1; din = 32'hD1;
        tick(); #1;
        check("pad_ready", 32'(din_ready), 32'd1);
        tick();
        din_valid = 1'b0; ovr_cnt = 4'd7; #1;
        check("pad_data_write", 32'(fifo_we), 32'd1);
        check("pad_ready_low", 32'(din_ready), 32'd0);
        check("pad_not_done", 32'(op_done), 32'd0);
        tick();
        check("pad_stalled", 32'(fifo_we), 32'd0);
        check("pad_count", 32'(loaded_count), 32'd1);
        reset = 1'b1; ovr_cnt = 4'd0;
        tick();
        check("prst_fifo_we", 32'(fifo_we), 32'd0);
        check("prst_fifo_dout", fifo_dout, 32'd0);
        check("prst_loaded_count", 32'(loaded_count), 32'd0);
        check("prst_op_done", 32'(op_done), 32'd0);
        check("prst_din_ready", 32'(din_ready), 32'd0);
        reset = 1'b0; op_start = 1'b0; ovr_en = 1'b0;
        sum_model = 32'd0;
        repeat (2) tick();
        check("prst_no_late_pad", 32'(fifo_we), 32'd0);
        check("prst_queue_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        for (int r = 0; r < 24; r++) begin
            logic [3:0] len;
            int         lc;
            len = 4'($urandom_range(15));
            lc  = (len > 4'd8) ? 8 : int'(len);
            run_load(len, 32'd0, 1'b1, int'($urandom_range(100, 30)), int'($urandom_range(100, 20)),
                     lc + (lc % 2), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
